// File: rtl/serial_sort4.sv
// Four-word serial sorter: loads four words, sorts them in place with a
// five-step compare-exchange network on one comparator, then streams them out.
//
// state | meaning
// LOAD  | accepting words into slots 0..3 in arrival order
// SORT  | one compare-exchange per cycle, steps 0..4
// SEND  | presenting slot[index] until all four are handed off
module serial_sort4 #(
  parameter int W          = 4,
  parameter bit DESCENDING = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   k_q, k_d;
  logic [2:0]   step_q, step_d;
  logic [1:0]   idx_q, idx_d;
  logic [W-1:0] slot_q [4];
  logic [W-1:0] slot_d [4];

  logic [1:0]   cmp_i, cmp_j;
  logic [W-1:0] cmp_a, cmp_b;
  logic         do_swap;

  // Network order (0,2),(1,3),(0,1),(2,3),(1,2) fully sorts four keys.
  always_comb begin
    cmp_i = 2'd1;
    cmp_j = 2'd2;
    case (step_q)
      3'd0: begin cmp_i = 2'd0; cmp_j = 2'd2; end
      3'd1: begin cmp_i = 2'd1; cmp_j = 2'd3; end
      3'd2: begin cmp_i = 2'd0; cmp_j = 2'd1; end
      3'd3: begin cmp_i = 2'd2; cmp_j = 2'd3; end
      default: begin cmp_i = 2'd1; cmp_j = 2'd2; end
    endcase
  end

  assign cmp_a   = slot_q[cmp_i];
  assign cmp_b   = slot_q[cmp_j];
  assign do_swap = DESCENDING ? (cmp_a < cmp_b) : (cmp_a > cmp_b);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    step_d  = step_q;
    idx_d   = idx_q;
    for (int i = 0; i < 4; i++) slot_d[i] = slot_q[i];

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          slot_d[k_q] = in_data;
          k_d         = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = SORT;
            step_d  = 3'd0;
          end
        end
      end
      SORT: begin
        if (do_swap) begin
          slot_d[cmp_i] = cmp_b;
          slot_d[cmp_j] = cmp_a;
        end
        if (step_q == 3'd4) begin
          state_d = SEND;
          idx_d   = 2'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      SEND: begin
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = LOAD;
            k_d     = 2'd0;
          end
        end
      end
      default: begin
        state_d = LOAD;
        k_d     = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      k_q     <= 2'd0;
      step_q  <= 3'd0;
      idx_q   <= 2'd0;
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      for (int i = 0; i < 4; i++) slot_q[i] <= slot_d[i];
    end
  end

  // in_ready is the only output allowed to see rst directly.
  assign in_ready  = (state_q == LOAD) && !rst;
  assign out_valid = (state_q == SEND);
  assign out_data  = (state_q == SEND) ? slot_q[idx_q] : '0;
  assign busy      = (state_q != LOAD);

endmodule

// File: tb/tb_serial_sort4.sv
// Scoreboard bench: two sorters (descending and ascending) share stimulus;
// a reference model sorts each accepted group of four and predicts handshakes.
module tb_serial_sort4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         ir_d, ov_d, busy_d, ir_a, ov_a, busy_a;
  logic [W-1:0] od_d, od_a;

  always #5 clk = ~clk;

  serial_sort4 #(.W(W), .DESCENDING(1'b1)) u_desc (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir_d), .out_data(od_d), .out_valid(ov_d),
    .out_ready(out_ready), .busy(busy_d));

  serial_sort4 #(.W(W), .DESCENDING(1'b0)) u_asc (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir_a), .out_data(od_a), .out_valid(ov_a),
    .out_ready(out_ready), .busy(busy_a));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit started = 0;
  bit rst_prev = 0;
  bit pend = 0;
  int c4 = 0;
  int grp[$];
  int exp_d[$];
  int exp_a[$];
  int s[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference model: a group is pending from the cycle after its fourth
  // accepted word until its last word is handed off; outputs start 6 cycles
  // after that fourth acceptance.
  always @(negedge clk) begin
    bit ov_exp;
    int t;
    if (started) begin
      if (rst) begin
        chk("in_ready_in_rst_desc", int'(ir_d), 0);
        chk("in_ready_in_rst_asc", int'(ir_a), 0);
        if (rst_prev) begin
          chk("out_valid_in_rst", int'(ov_d), 0);
          chk("out_data_in_rst", int'(od_d), 0);
          chk("busy_in_rst", int'(busy_d), 0);
        end
        pend = 0;
        grp.delete();
        exp_d.delete();
        exp_a.delete();
      end else begin
        ov_exp = pend && (cyc >= c4 + 6) && (exp_d.size() > 0);
        chk("in_ready_desc", int'(ir_d), int'(!pend));
        chk("in_ready_asc", int'(ir_a), int'(!pend));
        chk("busy_desc", int'(busy_d), int'(pend));
        chk("busy_asc", int'(busy_a), int'(pend));
        chk("out_valid_desc", int'(ov_d), int'(ov_exp));
        chk("out_valid_asc", int'(ov_a), int'(ov_exp));
        chk("out_data_desc", int'(od_d), ov_exp ? exp_d[0] : 0);
        chk("out_data_asc", int'(od_a), ov_exp ? exp_a[0] : 0);
        if (!pend) begin
          if (in_valid) begin
            grp.push_back(int'(in_data));
            if (grp.size() == 4) begin
              for (int i = 0; i < 4; i++) s[i] = grp[i];
              for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3 - i; j++)
                  if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                  end
              for (int i = 0; i < 4; i++) begin
                exp_a.push_back(s[i]);
                exp_d.push_back(s[3-i]);
              end
              grp.delete();
              pend = 1;
              c4 = cyc;
            end
          end
        end else if (ov_exp && out_ready) begin
          void'(exp_d.pop_front());
          void'(exp_a.pop_front());
          if (exp_d.size() == 0) pend = 0;
        end
      end
      rst_prev = rst;
    end
  end

  task automatic send_word(input int w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = W'(w);
    @(negedge clk);
    while (!ir_d && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_word_timeout", n, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy_d || !ir_d) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_idle_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_group(input int a, input int b, input int c, input int d);
    send_word(a); send_word(b); send_word(c); send_word(d);
  endtask

  initial begin
    int n;
    int gv[7];
    int gd[7];
    gv = '{1, 0, 0, 1, 1, 0, 1};
    gd = '{15, 3, 6, 0, 8, 11, 2};

    in_valid = 1'b1;
    in_data  = 4'hA;
    @(posedge clk); #1;
    started = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Back-to-back group, no backpressure.
    send_group(3, 9, 1, 7);
    wait_idle();

    // Equal words: busy spans 5 sort + 4 send cycles.
    send_group(5, 5, 5, 5);
    n = 0;
    while (busy_d && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy_cycles_equal_group", n, 9);
    wait_idle();

    // Gapped in_valid with junk data during the gaps.
    for (int i = 0; i < 7; i++) begin
      in_valid = gv[i][0];
      in_data  = W'(gd[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();

    // Backpressure at output index 1.
    send_group(3, 9, 1, 7);
    n = 0;
    @(negedge clk);
    while (!ov_d && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("first_valid_timeout", int'(n >= 50), 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    // Reset pulse during SORT step 2 abandons the group.
    send_group(8, 4, 12, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    send_group(0, 1, 2, 3);
    wait_idle();

    // in_valid held high with changing data through SORT and SEND.
    send_group(2, 14, 7, 7);
    for (int i = 0; i < 26; i++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // Random traffic with backpressure and rare resets.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = W'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_d.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
